weight_sram_banked_ctrl: RTL
============================

WEIGHT_SRAM_BANKED_CTRL -- requirements
Module: weight_sram_banked_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 25, number of SRAM banks (1..32).
REQ-002 SHALL have parameter BANK_DEPTH, default 2048, words per bank (power of two).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, word-address width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have req_valid  in  1  request present.
REQ-007 SHALL have req_ready  out  1  request accepted when req_valid and req_ready are both 1 at a rising edge (the acceptance edge E0).
REQ-008 SHALL have req_write  in  1  1 = write, 0 = read.
REQ-009 SHALL have req_addr  in  ADDR_WIDTH  word address.
REQ-010 SHALL have req_len  in  8  read burst length in words, where 0 is treated as 1; ignored for writes.
REQ-011 SHALL have req_wdata  in  DATA_WIDTH  write data.
REQ-012 SHALL have rsp_valid  out  1, rsp_data  out  DATA_WIDTH, and rsp_last  out  1 as the read-response beat, its data, and the final-beat flag.
REQ-013 SHALL have w_done  out  1  one-cycle write-complete pulse.
REQ-014 SHALL have err  out  1  one-cycle out-of-range pulse.

Function
REQ-015 SHALL decode addresses as row = req_addr[RW-1:0] and bank = req_addr[RW+BW-1:RW], with RW = clog2(BANK_DEPTH) and BW = clog2(NUM_BANKS).
REQ-016 SHALL treat an address as in range only when bank < NUM_BANKS and all bits above RW+BW are zero.
REQ-017 SHALL model each bank as a single-port synchronous array with a registered read and one cycle of latency, and SHALL enable only the addressed bank in any cycle.
REQ-018 SHALL use a two-state FSM: IDLE (req_ready = 1) and BURST (req_ready = 0).
REQ-019 SHALL, for an in-range write accepted at E0, update memory by edge E0+1, pulse w_done for the cycle after E0+1, and remain in IDLE.
REQ-020 SHALL issue beat k of an accepted read, with effective length L, at edge E0+k to address req_addr+k.
REQ-021 SHALL assert rsp_valid for beat k with its data during the cycle after edge E0+k+1.
REQ-022 SHALL increment burst addresses linearly, so that bank b row BANK_DEPTH-1 is followed by bank b+1 row 0.
REQ-023 SHALL remain in IDLE when L = 1, so that back-to-back single reads or writes sustain one request per cycle.
REQ-024 SHALL enter BURST after E0 when L > 1, and return to IDLE in the cycle after the last beat is issued.
REQ-025 SHALL assert rsp_last on the final beat of every read, and SHALL never assert rsp_valid in consecutive cycles across two different requests without rsp_last in between.
REQ-026 SHALL, for a request whose start address is out of range, perform no access, produce no response or w_done, and pulse err in the cycle after E0+1.
REQ-027 SHALL truncate a burst whose end exceeds NUM_BANKS*BANK_DEPTH-1 after the last in-range word, assert rsp_last on that beat, and pulse err in the same cycle.
REQ-028 SHALL return the new data for a read of address A accepted at E0+1 following a write to A accepted at E0.
REQ-029 SHALL never hold w_done and rsp_valid high in the same cycle from the same request.
REQ-030 SHALL produce rsp_data equal to 0 whenever rsp_valid = 0.

Reset
REQ-031 SHALL, while reset_n = 0 and regardless of clock, force req_ready = 0, rsp_valid = 0, rsp_last = 0, rsp_data = 0, w_done = 0, and err = 0, and force the FSM to IDLE.
REQ-032 SHALL drive req_ready to 1 in the first cycle after reset_n deasserts.
REQ-033 SHALL abort an in-flight burst on reset, so that no further beats, rsp_last or err appear after reset_n rises.
REQ-034 SHALL leave SRAM contents unmodified by reset.

Verification
REQ-035 Single write/read: write 0xDEADBEEF to addr 0x0005, read 0x0005 next cycle -> w_done pulse after E0+1; rsp_valid = 1, rsp_data = 0xDEADBEEF, rsp_last = 1 two edges after the read's E0.
REQ-036 Bank-crossing burst: preload addr 2046..2049 with 1..4, read addr 2046 len 4 -> four consecutive beats 1,2,3,4 with rsp_last on 4 only; req_ready = 0 for 3 cycles.
REQ-037 Out of range: read addr 51200 (defaults) -> no rsp_valid, err pulse after E0+1; write 0x10000 -> no memory change, no w_done, err pulse.
REQ-038 Truncation: read addr 51198 len 5 -> two beats, rsp_last and err together on the second beat.
REQ-039 Throughput: ten back-to-back single reads, req_valid held 1 -> ten rsp_valid cycles contiguous, each with rsp_last = 1.
REQ-040 Reset mid-burst: read len 8, assert reset_n = 0 after beat 2 -> all outputs 0 immediately, no beats after release, prior memory contents readable afterward.

Source files
------------

// File: rtl/weight_sram_banked_ctrl.sv
// weight_sram_banked_ctrl: banked weight SRAM with single writes, linear read bursts and range checking
module weight_sram_banked_ctrl #(
  parameter int NUM_BANKS  = 25,
  parameter int BANK_DEPTH = 2048,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  w_done,
  output logic                  err
);
  localparam int RW = $clog2(BANK_DEPTH);
  localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(NUM_BANKS * BANK_DEPTH - 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cur_addr, iss_addr;
  logic [7:0] rem, len_eff, iss_rem;
  logic accept, in_range, issue, iss_write, iss_last;
  logic [BW-1:0] iss_bank, s1_bank;
  logic s1_rd, s1_last, s1_trunc, s1_wr, s1_oor;
  logic [DATA_WIDTH-1:0] rd [NUM_BANKS];
  assign req_ready = reset_n && state == IDLE;
  assign accept    = req_valid && req_ready;
  assign len_eff   = req_len == 8'd0 ? 8'd1 : req_len;
  assign iss_addr  = state == BURST ? cur_addr : req_addr;
  assign iss_rem   = state == BURST ? rem : (req_write ? 8'd1 : len_eff);
  assign iss_write = state == IDLE && req_write;
  assign in_range  = iss_addr <= MAX_ADDR;
  assign issue     = state == BURST || (accept && in_range);
  // a beat is final when the burst is exhausted or it hits the top of the address space
  assign iss_last  = iss_rem == 8'd1 || iss_addr == MAX_ADDR;
  assign iss_bank  = iss_addr[RW+BW-1:RW];
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] ram [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] q;
    always_ff @(posedge clock)
      if (issue && iss_bank == BW'(b)) begin
        if (iss_write) ram[iss_addr[RW-1:0]] <= req_wdata;
        else q <= ram[iss_addr[RW-1:0]];
      end
    assign rd[b] = q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      rem       <= '0;
      s1_rd     <= 1'b0;
      s1_last   <= 1'b0;
      s1_trunc  <= 1'b0;
      s1_wr     <= 1'b0;
      s1_oor    <= 1'b0;
      s1_bank   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      w_done    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= issue && !iss_write && !iss_last ? BURST : IDLE;
      cur_addr  <= iss_addr + 1'b1;
      rem       <= iss_rem - 8'd1;
      s1_rd     <= issue && !iss_write;
      s1_last   <= iss_last;
      s1_trunc  <= iss_addr == MAX_ADDR && iss_rem > 8'd1;
      s1_wr     <= issue && iss_write;
      s1_oor    <= accept && !in_range;
      s1_bank   <= iss_bank;
      rsp_valid <= s1_rd;
      rsp_data  <= s1_rd ? rd[s1_bank] : '0;
      rsp_last  <= s1_rd && s1_last;
      w_done    <= s1_wr;
      err       <= s1_oor || (s1_rd && s1_trunc);
    end
endmodule
